// File: rtl/edge_event_arbiter.sv
// Per-channel rising-edge detector on update-strobe samples, arbitrated onto one event port (fixed priority when EDGE_ARB_FIXED_PRIO_EN).
// Latency: pending set at edge T, event presented after edge T+1 when the output register is free.
// Backpressure: ev_valid/ev_ch held while ev_ready=0; further rises on a pending channel raise sticky overflow.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update,
    input  logic [NUM_CH-1:0] level,
    input  logic [NUM_CH-1:0] enable,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [CH_W-1:0]   ev_ch,
    output logic [NUM_CH-1:0] overflow,
    output logic              busy
);

    localparam logic [1:0] ST_ONE  = 2'd0;
    localparam logic [1:0] ST_ZERO = 2'd1;
    localparam logic [1:0] ST_RISE = 2'd2;

    logic [1:0]        state     [NUM_CH];
    logic [1:0]        state_nxt [NUM_CH];
    logic              upd_prev;
    logic              tick;
    logic              load;
    logic              found;
    logic              found_hi;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   grant_hi;
    logic [CH_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] rise_entry;
    logic [NUM_CH-1:0] grant_clr;

    assign tick = update & ~upd_prev;
    assign load = ~ev_valid | ev_ready;
    // Disabled channels never win, so a pending bit being cleared cannot leak out as an event.
    assign req  = pending & enable;
    assign busy = ev_valid | (|pending);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i]  = state[i];
            rise_entry[i] = 1'b0;
            if (tick) begin
                case (state[i])
                    ST_ONE:  if (!level[i]) state_nxt[i] = ST_ZERO;
                    ST_ZERO: if (level[i]) begin
                        state_nxt[i]  = ST_RISE;
                        rise_entry[i] = 1'b1;
                    end
                    ST_RISE: state_nxt[i] = level[i] ? ST_ONE : ST_ZERO;
                    default: state_nxt[i] = ST_ONE;
                endcase
            end
        end
    end

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        found_hi = 1'b0;
        grant_hi = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (req[j] && !found) begin
                found = 1'b1;
                grant = CH_W'(j);
            end
            if (req[j] && !found_hi && (j >= int'(rr_ptr))) begin
                found_hi = 1'b1;
                grant_hi = CH_W'(j);
            end
        end
        if (found_hi) grant = grant_hi;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            grant_clr[i] = load & found & (int'(grant) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            upd_prev <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) state[i] <= ST_ONE;
        end else begin
            upd_prev <= update;
            for (int i = 0; i < NUM_CH; i++) state[i] <= state_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable[i]) begin
                    pending[i] <= 1'b0;
                end else if (rise_entry[i]) begin
                    pending[i] <= 1'b1;
                    if (pending[i] && !grant_clr[i]) overflow[i] <= 1'b1;
                end else if (grant_clr[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (found) begin
                ev_valid <= 1'b1;
                ev_ch    <= grant;
`ifdef EDGE_ARB_FIXED_PRIO_EN
                rr_ptr   <= '0;
`else
                rr_ptr   <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
`endif
            end else begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized + directed bench for edge_event_arbiter with a sample-history reference model and event scoreboard.
module tb_edge_event_arbiter;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              update;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] enable;
    logic              ev_ready;
    logic              ev_valid;
    logic [CH_W-1:0]   ev_ch;
    logic [NUM_CH-1:0] overflow;
    logic              busy;

    int total = 0;
    int bad   = 0;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .update(update), .level(level), .enable(enable),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_ch(ev_ch),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a channel rises when a tick samples 1 and the previous sample was 0;
    // after reset the previous sample is taken to be 1.
    bit              m_last [NUM_CH];
    bit              m_pend [NUM_CH];
    bit              m_ovf  [NUM_CH];
    bit              m_valid;
    bit              m_upd_prev;
    int              m_rr;
    int              exp_q [$];

    function automatic logic [NUM_CH-1:0] pack(input bit a [NUM_CH]);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_last[i] = 1'b1;
                m_pend[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
            m_valid    = 1'b0;
            m_upd_prev = 1'b0;
            m_rr       = 0;
            exp_q.delete();
        end else begin
            bit tick;
            bit ld;
            bit rise [NUM_CH];
            int g;
            tick = update && !m_upd_prev;
            ld   = !m_valid || ev_ready;
            g    = -1;
            if (ld) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    int c;
                    c = (m_rr + k) % NUM_CH;
                    if (g < 0 && m_pend[c] && enable[c]) g = c;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                rise[i] = tick && !m_last[i] && level[i];
                if (tick) m_last[i] = level[i];
                if (!enable[i]) m_pend[i] = 1'b0;
                else if (rise[i]) begin
                    if (m_pend[i] && g != i) m_ovf[i] = 1'b1;
                    m_pend[i] = 1'b1;
                end else if (g == i) m_pend[i] = 1'b0;
            end
            if (ld) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    exp_q.push_back(g);
`ifdef EDGE_ARB_FIXED_PRIO_EN
                    m_rr = 0;
`else
                    m_rr = (g + 1) % NUM_CH;
`endif
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_upd_prev = update;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each accepted event is popped from the scoreboard; per-cycle status checked against the model.
    always @(negedge clk) begin
        chk("ev_valid", {31'b0, ev_valid}, {31'b0, m_valid});
        chk("busy", {31'b0, busy}, {31'b0, (m_valid || (|pack(m_pend)))});
        chk("overflow", {28'b0, overflow}, {28'b0, pack(m_ovf)});
        if (reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ev_ch: got %0d expected no event at %0t", ev_ch, $time);
            end else begin
                chk("ev_ch", {30'b0, ev_ch}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        update = 1'b0;
        step(2);
        reset  = 1'b1;
    endtask

    task automatic tick(input logic [NUM_CH-1:0] lv);
        level  = lv;
        update = 1'b1;
        step();
        update = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; update = 1'b0; level = '0; enable = '1; ev_ready = 1'b0;
        do_reset();
        chk("reset_valid", {31'b0, ev_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ovf", {28'b0, overflow}, 32'd0);

        // First tick after reset with levels high must not fire; then 0 -> 1 on channel 0.
        ev_ready = 1'b1;
        tick(4'b1111);
        tick(4'b0000);
        tick(4'b0001);
        chk("lat_valid", {31'b0, ev_valid}, 32'd1);
        chk("lat_ch", {30'b0, ev_ch}, 32'd0);
        chk("lat_busy", {31'b0, busy}, 32'd1);
        step(3);

        // Update held high: only its leading edge samples.
        level = 4'b0000; update = 1'b1;
        for (int i = 0; i < 5; i++) begin
            level = ~level;
            step();
        end
        update = 1'b0;
        step(4);

        // Burst arbitration: two channels, then all four.
        do_reset();
        ev_ready = 1'b1;
        tick(4'b0000);
        tick(4'b0011);
        step(4);
        tick(4'b0000);
        tick(4'b1111);
        step(6);

        // Overflow: ch1 occupies the output, ch2 rises twice while stalled.
        do_reset();
        ev_ready = 1'b0;
        tick(4'b0000);
        tick(4'b0010);
        tick(4'b0110);
        tick(4'b0010);
        tick(4'b0110);
        chk("ovf_flag", {28'b0, overflow}, 32'h4);
        chk("ovf_hold_ch", {30'b0, ev_ch}, 32'd1);
        chk("ovf_hold_vld", {31'b0, ev_valid}, 32'd1);
        ev_ready = 1'b1;
        step(4);
        chk("ovf_sticky", {28'b0, overflow}, 32'h4);

        // Enable masking.
        do_reset();
        enable = 4'b1110; ev_ready = 1'b1;
        tick(4'b0000);
        tick(4'b0001);
        step(2);
        chk("mask_busy", {31'b0, busy}, 32'd0);
        ev_ready = 1'b0;
        tick(4'b0100);
        tick(4'b0110);
        enable = 4'b1100;
        step();
        enable = 4'b1110;
        step();
        ev_ready = 1'b1;
        step(3);
        chk("mask_drain_busy", {31'b0, busy}, 32'd0);
        enable = '1;

        // Reset mid-handshake drops the presented event.
        ev_ready = 1'b0;
        tick(4'b0000);
        tick(4'b0001);
        tick(4'b0011);
        chk("pre_rst_vld", {31'b0, ev_valid}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_vld", {31'b0, ev_valid}, 32'd0);
        chk("rst_ovf", {28'b0, overflow}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        step(2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            update   = 1'($urandom_range(0, 1));
            level    = NUM_CH'($urandom);
            ev_ready = ($urandom_range(0, 9) < 6);
            enable   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '1;
            reset    = ($urandom_range(0, 399) != 0);
            step();
        end
        reset = 1'b1; update = 1'b0; ev_ready = 1'b1; enable = '1;
        step(10);
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
